// File: rtl/rf_sched_pkg.sv
// Shared constants for the register-file write scheduler.
package rf_sched_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NREGS  = 32;
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;
endpackage

// File: rtl/rf_wr_hold.sv
// One-entry write holding register; load wins over clear, flush wins over both.
// Latency 1 cycle from load to valid; the parent decides when loading is allowed.
module rf_wr_hold
  import rf_sched_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 load_i,
  input  logic                 clear_i,
  input  logic [RF_ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0]    data_i,
  output logic                 vld_o,
  output logic [RF_ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0]    data_o
);
  logic                 vld_q, vld_d;
  logic [RF_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]    data_q;

  always_comb begin
    vld_d = vld_q;
    if (flush_i)      vld_d = 1'b0;
    else if (load_i)  vld_d = 1'b1;
    else if (clear_i) vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (load_i && !flush_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end

  assign vld_o  = vld_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
endmodule

// File: rtl/rf_write_scheduler.sv
// Round-robin share of the RF write port between ALU (A) and load (B) writeback.
// Optional RF_R0_DISCARD_EN: writes to r0 use their grant slot but raise no strobe.
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 a_valid,
  input  logic [RF_ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0]    a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [RF_ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 b_ready,
  output logic [RF_NREGS-1:0]  rf_we,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 busy,
  output logic [CNT_W-1:0]     contention_cnt
);
  function automatic logic [RF_NREGS-1:0] decode_onehot(input logic [RF_ADDR_W-1:0] addr);
    logic [RF_NREGS-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

  logic                 hold_a_vld, hold_b_vld;
  logic [RF_ADDR_W-1:0] hold_a_addr, hold_b_addr;
  logic [DATA_W-1:0]    hold_a_dat, hold_b_dat;
  logic                 grant_a, grant_b, issue, wr_en;
  logic [RF_ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0]    g_dat;
  logic                 rr_last_q, rr_last_d;
  logic [RF_NREGS-1:0]  rf_we_q, rf_we_d;
  logic [DATA_W-1:0]    rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Grant looks only at registered hold state, keeping valid->ready free of loops.
  assign grant_a = hold_a_vld && (!hold_b_vld || rr_last_q == CH_B);
  assign grant_b = hold_b_vld && (!hold_a_vld || rr_last_q == CH_A);
  assign a_ready = !flush && (!hold_a_vld || grant_a);
  assign b_ready = !flush && (!hold_b_vld || grant_b);

  rf_wr_hold #(.DATA_W(DATA_W)) u_hold_a (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .load_i(a_valid && a_ready),
    .clear_i(grant_a), .addr_i(a_addr), .data_i(a_data),
    .vld_o(hold_a_vld), .addr_o(hold_a_addr), .data_o(hold_a_dat)
  );

  rf_wr_hold #(.DATA_W(DATA_W)) u_hold_b (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .load_i(b_valid && b_ready),
    .clear_i(grant_b), .addr_i(b_addr), .data_i(b_data),
    .vld_o(hold_b_vld), .addr_o(hold_b_addr), .data_o(hold_b_dat)
  );

  assign issue  = !flush && (grant_a || grant_b);
  assign g_addr = grant_a ? hold_a_addr : hold_b_addr;
  assign g_dat  = grant_a ? hold_a_dat : hold_b_dat;
`ifdef RF_R0_DISCARD_EN
  assign wr_en = issue && (g_addr != '0);
`else
  assign wr_en = issue;
`endif

  always_comb begin
    rf_we_d    = '0;
    rf_wdata_d = rf_wdata_q;
    rr_last_d  = rr_last_q;
    cnt_d      = cnt_q;
    if (wr_en) begin
      rf_we_d    = decode_onehot(g_addr);
      rf_wdata_d = g_dat;
    end
    if (issue) rr_last_d = grant_a ? CH_A : CH_B;
    if (!flush && hold_a_vld && hold_b_vld && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + CNT_W'(1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= '0;
      rf_wdata_q <= '0;
      rr_last_q  <= CH_B;
      cnt_q      <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_wdata_q <= rf_wdata_d;
      rr_last_q  <= rr_last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rf_we          = rf_we_q;
  assign rf_wdata       = rf_wdata_q;
  assign contention_cnt = cnt_q;
  assign busy           = hold_a_vld || hold_b_vld || (|rf_we_q);
endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: directed table, corner sequences, random traffic vs model.
module tb_rf_write_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, busy;
  logic [31:0] rf_we, rf_wdata;
  logic [3:0]  contention_cnt;

  int errors = 0;
  int checks = 0;

  rf_write_scheduler #(.DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .busy(busy), .contention_cnt(contention_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: two holding slots, last-winner flag, output registers.
  bit          m_hv[2];
  logic [4:0]  m_ha[2];
  logic [31:0] m_hd[2];
  bit          m_rr_b;
  logic [31:0] m_we, m_wd;
  int          m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hv[0] = 0; m_hv[1] = 0;
    m_ha[0] = '0; m_ha[1] = '0;
    m_hd[0] = '0; m_hd[1] = '0;
    m_rr_b = 1;
    m_we = '0; m_wd = '0; m_cnt = 0;
  endtask

  task automatic check_outputs();
    chk("rf_we", rf_we, m_we);
    chk("rf_wdata", rf_wdata, m_wd);
    chk("busy", {31'b0, busy}, {31'b0, m_hv[0] | m_hv[1] | (m_we != 0)});
    chk("contention_cnt", {28'b0, contention_cnt}, m_cnt);
  endtask

  // Drive one cycle of inputs, check readies, clock, then check registered outputs.
  task automatic step(input logic fl, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    bit ga, gb, ra, rb, wr;
    int idx;
    flush = fl; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    ga = m_hv[0] && (!m_hv[1] || m_rr_b);
    gb = m_hv[1] && (!m_hv[0] || !m_rr_b);
    ra = !fl && (!m_hv[0] || ga);
    rb = !fl && (!m_hv[1] || gb);
    #1;
    chk("a_ready", {31'b0, a_ready}, {31'b0, ra});
    chk("b_ready", {31'b0, b_ready}, {31'b0, rb});
    @(posedge clk);
    if (fl) begin
      m_hv[0] = 0; m_hv[1] = 0; m_we = '0;
    end else begin
      if (m_hv[0] && m_hv[1] && m_cnt < 15) m_cnt++;
      m_we = '0;
      if (ga || gb) begin
        idx = ga ? 0 : 1;
        m_rr_b = (idx == 1);
        wr = 1;
`ifdef RF_R0_DISCARD_EN
        if (m_ha[idx] == 5'd0) wr = 0;
`endif
        if (wr) begin
          m_we = 32'd1 << m_ha[idx];
          m_wd = m_hd[idx];
        end
        m_hv[idx] = 0;
      end
      if (av && ra) begin m_hv[0] = 1; m_ha[0] = aa; m_hd[0] = ad; end
      if (bv && rb) begin m_hv[1] = 1; m_ha[1] = ba; m_hd[1] = bd; end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 0; a_valid = 0; b_valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    #1;
    chk("rst a_ready", {31'b0, a_ready}, 32'd1);
    chk("rst b_ready", {31'b0, b_ready}, 32'd1);
  endtask

  typedef struct {
    logic fl, av; logic [4:0] aa; logic [31:0] ad;
    logic bv; logic [4:0] ba; logic [31:0] bd;
    logic [31:0] we, wd; logic busy; int cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // Tie straight after reset (A first), then a lone A write to r3.
    tbl[0] = '{0, 1, 5'd1, 32'd11, 1, 5'd31, 32'd22, 32'h0, 32'h0, 1, 0};
    tbl[1] = '{0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 32'h0000_0002, 32'd11, 1, 1};
    tbl[2] = '{0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 32'h8000_0000, 32'd22, 1, 1};
    tbl[3] = '{0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 32'h0, 32'd22, 0, 1};
    tbl[4] = '{0, 1, 5'd3, 32'hDEAD_BEEF, 0, 5'd0, 32'd0, 32'h0, 32'd22, 1, 1};
    tbl[5] = '{0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 32'h0000_0008, 32'hDEAD_BEEF, 1, 1};
    tbl[6] = '{0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 32'h0, 32'hDEAD_BEEF, 0, 1};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].fl, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd);
      chk("tbl rf_we", rf_we, tbl[i].we);
      chk("tbl rf_wdata", rf_wdata, tbl[i].wd);
      chk("tbl busy", {31'b0, busy}, {31'b0, tbl[i].busy});
      chk("tbl cnt", {28'b0, contention_cnt}, tbl[i].cnt);
    end

    // Streaming: A every cycle to r0..r7.
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 5'(i), 32'h100 + i, 0, 5'd0, 32'd0);
      chk("stream a_ready", {31'b0, a_ready}, 32'd1);
    end
    repeat (2) idle();

    // Flush with both holds full.
    step(0, 1, 5'd2, 32'hAAAA, 1, 5'd9, 32'hBBBB);
    step(1, 1, 5'd5, 32'hCCCC, 1, 5'd6, 32'hDDDD);
    chk("flush rf_we", rf_we, 32'h0);
    chk("flush busy", {31'b0, busy}, 32'd0);
    step(0, 0, 5'd0, 32'd0, 1, 5'd4, 32'h4444);
    idle();
    chk("post-flush rf_we", rf_we, 32'h0000_0010);
    chk("post-flush rf_wdata", rf_wdata, 32'h4444);
    idle();

    // Saturation from a clean counter.
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 1, 5'(i), 32'(i), 1, 5'(31 - i), 32'(i + 100));
    chk("sat cnt", {28'b0, contention_cnt}, 32'hF);
    repeat (3) idle();

    // Register 0 write.
    step(0, 1, 5'd0, 32'h5A5A, 0, 5'd0, 32'd0);
    idle();
`ifdef RF_R0_DISCARD_EN
    chk("r0 rf_we", rf_we, 32'h0);
    chk("r0 busy", {31'b0, busy}, 32'd0);
`else
    chk("r0 rf_we", rf_we, 32'h0000_0001);
`endif
    idle();

    // Asynchronous reset while a write strobe is high.
    step(0, 1, 5'd7, 32'h77, 1, 5'd8, 32'h88);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rf_we", rf_we, 32'h0);
    chk("async busy", {31'b0, busy}, 32'd0);
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] ra, rb;
      ra = 5'($urandom);
      rb = 5'($urandom);
      if ($urandom_range(7, 0) == 0) ra = 5'd0;
      step(($urandom_range(19, 0) == 0), ($urandom_range(3, 0) != 0), ra, $urandom,
           ($urandom_range(2, 0) != 0), rb, $urandom);
    end
    repeat (3) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
